// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/accept signals for both requesters plus the register
// file write port and init status, grouped for the arbiter and its clients.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_busy;

  // arbiter side
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mc_valid, mc_addr, mc_data,
    output wb_ready, mc_ready,
    output rf_we, rf_waddr, rf_wdata, init_busy
  );

  // requester / register file side
  modport master (
    output wb_valid, wb_addr, wb_data,
    output mc_valid, mc_addr, mc_data,
    input  wb_ready, mc_ready,
    input  rf_we, rf_waddr, rf_wdata, init_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: optional post-reset init sequence
// (reg i <- i*INIT_MULT, enabled by macro RF_INIT_SEQ_EN), then arbitration
// between the pipeline WB stage (req 0) and a multicycle unit (req 1).
// Req 0 normally wins; req 1 takes priority after STARVE_LIMIT denied cycles.
// Writes to register 0 are accepted but never reach the register file.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int INIT_MULT    = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  // reject parameter values the starve counter or init data cannot represent
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || INIT_MULT < 0) begin : g_bad_param
    $error("regfile_wb_arbiter: STARVE_LIMIT must be 1..15, INIT_MULT >= 0");
  end

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              run;
  logic              mc_pri;
  logic              wb_gnt;
  logic              mc_gnt;
  logic [3:0]        starve;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef RF_INIT_SEQ_EN
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;

  // state register; reset always restarts the init sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  // leave INIT on the cycle the last register is written
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && idx == LAST) state_nxt = S_RUN;
  end

  // init index walks 1..2^ADDR_W-1, register 0 is skipped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 idx <= ADDR_W'(1);
    else if (state == S_INIT) idx <= idx + 1'b1;
  end

  assign run           = (state == S_RUN);
  assign bus.init_busy = (state == S_INIT);
`else
  assign run           = 1'b1;
  assign bus.init_busy = 1'b0;
`endif

  // grant: lone requester wins; on contention req 0 unless req 1 is starved
  assign mc_pri       = (starve == LIMIT);
  assign wb_gnt       = run && bus.wb_valid && (!bus.mc_valid || !mc_pri);
  assign mc_gnt       = run && bus.mc_valid && (!bus.wb_valid || mc_pri);
  assign bus.wb_ready = wb_gnt;
  assign bus.mc_ready = mc_gnt;

  // count consecutive cycles req 1 waits; saturate so priority sticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          starve <= '0;
    else if (!bus.mc_valid || mc_gnt)  starve <= '0;
    else if (starve != LIMIT)          starve <= starve + 4'd1;
  end

  // registered write port; addr/data hold when idle, x0 writes suppressed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end
`ifdef RF_INIT_SEQ_EN
    else if (!run) begin
      we_q    <= 1'b1;
      waddr_q <= idx;
      wdata_q <= DATA_W'(idx) * DATA_W'(INIT_MULT);
    end
`endif
    else if (wb_gnt) begin
      we_q    <= |bus.wb_addr;
      waddr_q <= bus.wb_addr;
      wdata_q <= bus.wb_data;
    end else if (mc_gnt) begin
      we_q    <= |bus.mc_addr;
      waddr_q <= bus.mc_addr;
      wdata_q <= bus.mc_data;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

endmodule
